mreq_tx_stream: RTL and testbench

MREQ_TX_STREAM -- requirements
Module: mreq_tx_stream

---
 rtl/mreq_tx_stream.sv | 237 +++++++++++++++++++++++
 tb/tb_mreq_tx_stream.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mreq_tx_stream.sv
// mreq_tx_stream: serializes a packed memory request into a byte stream.
// Frame layout: header, wcount, address bytes (MSB first), optional write
// payload taken from the i_wdata stream, optional XOR checksum byte.
// The output byte register only advances on a sink handshake, so a stalled
// sink freezes the frame in place.
module mreq_tx_stream #(
  parameter int ADDR_BYTES = 4,
  parameter int CHECKSUM   = 1,
  localparam int MW        = 12 + 8 * ADDR_BYTES
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_mreq_valid,
  output logic          o_mreq_ready,
  input  logic [MW-1:0] i_mreq,
  input  logic [7:0]    i_wdata,
  input  logic          i_wdata_valid,
  output logic          o_wdata_ready,
  output logic [7:0]    o_tx_data,
  output logic          o_tx_valid,
  input  logic          i_tx_ready,
  output logic          o_busy
);

  localparam int AW = 8 * ADDR_BYTES;
  localparam logic [1:0] LAST_IDX = 2'(ADDR_BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_CNT  = 3'd2,
    S_ADDR = 3'd3,
    S_PAY  = 3'd4,
    S_CSUM = 3'd5
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [7:0]  tx_data_r;
  logic        tx_valid_r;
  logic        mreq_ready_r;
  logic [7:0]  csum_r;
  logic        wr_r;
  logic [7:0]  wcount_r;
  logic [31:0] addr_r;
  logic [1:0]  idx_r;
  logic [10:0] pay_cnt_r;
  logic        wdata_ready_s;
  logic        busy_s;

  // Running checksum step: each byte folds into the XOR accumulator.
  function automatic logic [7:0] csum_upd(input logic [7:0] c, input logic [7:0] b);
    return c ^ b;
  endfunction

  // Address byte i of the frame, counted from the most significant byte.
  function automatic logic [7:0] addr_byte(input logic [31:0] a, input logic [1:0] i);
    logic [4:0] sh;
    sh = 5'((ADDR_BYTES - 1 - int'(i)) * 8);
    return 8'(a >> sh);
  endfunction

  // Payload length in bytes: (wcount+1) beats of 1, 2 or 4 bytes; wsize 3 acts as 4.
  function automatic logic [10:0] pay_len(input logic [7:0] wc, input logic [1:0] ws);
    logic [10:0] base;
    logic [10:0] len;
    base = {3'b000, wc} + 11'd1;
    case (ws)
      2'd0:    len = base;
      2'd1:    len = base << 1;
      default: len = base << 2;
    endcase
    return len;
  endfunction

  // Request field decode, only consumed on the accept cycle.
  logic        req_wr_s;
  logic        req_aincr_s;
  logic [1:0]  req_wsize_s;
  logic [7:0]  req_wcount_s;
  logic [31:0] req_addr_s;
  logic [7:0]  hdr_s;
  assign req_wr_s     = i_mreq[MW-1];
  assign req_aincr_s  = i_mreq[MW-2];
  assign req_wsize_s  = i_mreq[MW-3:MW-4];
  assign req_wcount_s = i_mreq[MW-5:MW-12];
  assign req_addr_s   = 32'(i_mreq[AW-1:0]);
  assign hdr_s        = {req_wr_s, req_aincr_s, req_wsize_s, 4'(ADDR_BYTES - 1)};

  logic accept_s;
  logic tx_hs_s;
  logic wd_hs_s;
  assign accept_s = i_mreq_valid && mreq_ready_r;
  assign tx_hs_s  = tx_valid_r && i_tx_ready;
  assign wd_hs_s  = i_wdata_valid && wdata_ready_s;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: byte-carrying states advance on the sink handshake.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) state_nxt_s = S_HDR;
        else          state_nxt_s = S_IDLE;
      end
      S_HDR: begin
        if (tx_hs_s) state_nxt_s = S_CNT;
        else         state_nxt_s = S_HDR;
      end
      S_CNT: begin
        if (tx_hs_s) state_nxt_s = S_ADDR;
        else         state_nxt_s = S_CNT;
      end
      S_ADDR: begin
        if (tx_hs_s && (idx_r == LAST_IDX)) begin
          if (wr_r)                state_nxt_s = S_PAY;
          else if (CHECKSUM != 0)  state_nxt_s = S_CSUM;
          else                     state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_ADDR;
        end
      end
      S_PAY: begin
        if (tx_hs_s && (pay_cnt_r == 11'd0)) begin
          if (CHECKSUM != 0) state_nxt_s = S_CSUM;
          else               state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_PAY;
        end
      end
      S_CSUM: begin
        if (tx_hs_s) state_nxt_s = S_IDLE;
        else         state_nxt_s = S_CSUM;
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Output decode: payload is pulled only while bytes remain and the
  // output register is free or being drained this cycle.
  always_comb begin
    wdata_ready_s = 1'b0;
    busy_s        = (state_r != S_IDLE);
    if ((state_r == S_PAY) && (pay_cnt_r != 11'd0)) begin
      wdata_ready_s = !tx_valid_r || i_tx_ready;
    end else begin
      wdata_ready_s = 1'b0;
    end
  end

  // Datapath: request latch, output byte register, checksum and counters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tx_data_r    <= 8'h00;
      tx_valid_r   <= 1'b0;
      mreq_ready_r <= 1'b0;
      csum_r       <= 8'h00;
      wr_r         <= 1'b0;
      wcount_r     <= 8'h00;
      addr_r       <= 32'h0000_0000;
      idx_r        <= 2'd0;
      pay_cnt_r    <= 11'd0;
    end else begin
      mreq_ready_r <= (state_nxt_s == S_IDLE);
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            wr_r       <= req_wr_s;
            wcount_r   <= req_wcount_s;
            addr_r     <= req_addr_s;
            pay_cnt_r  <= pay_len(req_wcount_s, req_wsize_s);
            idx_r      <= 2'd0;
            tx_data_r  <= hdr_s;
            tx_valid_r <= 1'b1;
            csum_r     <= hdr_s;
          end
        end
        S_HDR: begin
          if (tx_hs_s) begin
            tx_data_r <= wcount_r;
            csum_r    <= csum_upd(csum_r, wcount_r);
          end
        end
        S_CNT: begin
          if (tx_hs_s) begin
            tx_data_r <= addr_byte(addr_r, 2'd0);
            csum_r    <= csum_upd(csum_r, addr_byte(addr_r, 2'd0));
          end
        end
        S_ADDR: begin
          if (tx_hs_s) begin
            if (idx_r == LAST_IDX) begin
              if (wr_r)               tx_valid_r <= 1'b0;
              else if (CHECKSUM != 0) tx_data_r  <= csum_r;
              else                    tx_valid_r <= 1'b0;
            end else begin
              idx_r     <= idx_r + 2'd1;
              tx_data_r <= addr_byte(addr_r, idx_r + 2'd1);
              csum_r    <= csum_upd(csum_r, addr_byte(addr_r, idx_r + 2'd1));
            end
          end
        end
        S_PAY: begin
          if (wd_hs_s) begin
            tx_data_r  <= i_wdata;
            tx_valid_r <= 1'b1;
            csum_r     <= csum_upd(csum_r, i_wdata);
            pay_cnt_r  <= pay_cnt_r - 11'd1;
          end else if (tx_hs_s) begin
            // Last payload byte gone: follow with the checksum, otherwise a bubble.
            if ((pay_cnt_r == 11'd0) && (CHECKSUM != 0)) tx_data_r  <= csum_r;
            else                                         tx_valid_r <= 1'b0;
          end
        end
        S_CSUM: begin
          if (tx_hs_s) tx_valid_r <= 1'b0;
        end
        default: tx_valid_r <= 1'b0;
      endcase
    end
  end

  assign o_tx_data     = tx_data_r;
  assign o_tx_valid    = tx_valid_r;
  assign o_mreq_ready  = mreq_ready_r;
  assign o_wdata_ready = wdata_ready_s;
  assign o_busy        = busy_s;

endmodule

// File: tb/tb_mreq_tx_stream.sv
// Bench for mreq_tx_stream: two instances (default params, and 2 address
// bytes without checksum), a frame-level model built from request fields,
// and a compare process that checks every sink handshake against it.
module tb_mreq_tx_stream;

  logic        clk;
  logic        rst_n;
  logic        mreq_valid [2];
  logic [43:0] mreq0;
  logic [27:0] mreq1;
  logic        mreq_ready_s [2];
  logic        tx_valid_s [2];
  logic        busy_s [2];
  logic        wdata_ready_s [2];
  logic        tx_ready [2];
  logic [7:0]  tx_data_s [2];
  logic [7:0]  wdata0;
  logic        wdata_valid0;

  mreq_tx_stream u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_mreq_valid(mreq_valid[0]), .o_mreq_ready(mreq_ready_s[0]), .i_mreq(mreq0),
    .i_wdata(wdata0), .i_wdata_valid(wdata_valid0), .o_wdata_ready(wdata_ready_s[0]),
    .o_tx_data(tx_data_s[0]), .o_tx_valid(tx_valid_s[0]), .i_tx_ready(tx_ready[0]),
    .o_busy(busy_s[0])
  );

  mreq_tx_stream #(.ADDR_BYTES(2), .CHECKSUM(0)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_mreq_valid(mreq_valid[1]), .o_mreq_ready(mreq_ready_s[1]), .i_mreq(mreq1),
    .i_wdata(8'h00), .i_wdata_valid(1'b0), .o_wdata_ready(wdata_ready_s[1]),
    .o_tx_data(tx_data_s[1]), .o_tx_valid(tx_valid_s[1]), .i_tx_ready(tx_ready[1]),
    .o_busy(busy_s[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int wd_hs_cnt = 0;
  int bubble_cnt = 0;
  int hs_cnt [2];
  int first_hs [2];
  int last_hs [2];

  logic [7:0] exp_q0 [$];
  logic [7:0] exp_q1 [$];
  logic [7:0] frame_q [$];
  logic [7:0] tmp_pay [$];
  int         tmp_gap [$];
  logic [7:0] pay_q [$];
  int         gap_q [$];
  logic [7:0] lit [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Frame model: bytes the sink must see, derived from the request fields.
  task automatic expect_frame(input int k, input logic wr, input logic aincr,
                              input logic [1:0] wsize, input logic [7:0] wcount,
                              input logic [31:0] addr, input int ab, input logic cs);
    logic [7:0] x;
    int plen;
    frame_q.delete();
    frame_q.push_back({wr, aincr, wsize, 4'(ab - 1)});
    frame_q.push_back(wcount);
    for (int i = ab - 1; i >= 0; i--) frame_q.push_back(8'(addr >> (8 * i)));
    if (wr) begin
      plen = (int'(wcount) + 1) << ((wsize == 2'd3) ? 2 : int'(wsize));
      chk("model_payload_len", 32'(tmp_pay.size()), 32'(plen));
      foreach (tmp_pay[i]) begin
        frame_q.push_back(tmp_pay[i]);
        pay_q.push_back(tmp_pay[i]);
        gap_q.push_back(tmp_gap[i]);
      end
    end
    if (cs) begin
      x = 8'h00;
      foreach (frame_q[i]) x = x ^ frame_q[i];
      frame_q.push_back(x);
    end
    foreach (frame_q[i]) begin
      if (k == 0) exp_q0.push_back(frame_q[i]);
      else        exp_q1.push_back(frame_q[i]);
    end
  endtask

  // Pin the model against hand-computed frames.
  task automatic pin(input string name);
    chk({name, "_len"}, 32'(frame_q.size()), 32'(lit.size()));
    for (int i = 0; i < lit.size() && i < frame_q.size(); i++)
      chk(name, 32'(frame_q[i]), 32'(lit[i]));
  endtask

  task automatic add_pay(input logic [7:0] b, input int g);
    tmp_pay.push_back(b);
    tmp_gap.push_back(g);
  endtask

  task automatic send_req(input int k, input logic [43:0] v);
    bit ok;
    ok = 1'b0;
    mreq_valid[k] = 1'b1;
    if (k == 0) mreq0 = v;
    else        mreq1 = v[27:0];
    for (int c = 0; c < 50 && !ok; c++) begin
      if (mreq_ready_s[k]) begin
        ok = 1'b1;
        accept_cyc = cyc + 1;
      end else begin
        @(negedge clk);
      end
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout dut%0d: o_mreq_ready got 0 expected 1", k);
    end
    @(posedge clk);
    #1;
    mreq_valid[k] = 1'b0;
    mreq0 = 44'hFFF_FFFF_FFFF;
    mreq1 = 28'hFFF_FFFF;
  endtask

  task automatic wait_done(input int k, input bit stall, input int maxc);
    bit done;
    done = 1'b0;
    for (int c = 0; c < maxc && !done; c++) begin
      @(posedge clk);
      #1;
      tx_ready[k] = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      if (!busy_s[k] && ((k == 0) ? (exp_q0.size() == 0) : (exp_q1.size() == 0))) begin
        done = 1'b1;
        chk("mreq_ready_after_frame", 32'(mreq_ready_s[k]), 32'd1);
      end
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL frame_timeout dut%0d: busy=%0d left=%0d expected idle with 0 left",
               k, busy_s[k], (k == 0) ? exp_q0.size() : exp_q1.size());
    end
    tx_ready[k] = 1'b1;
  endtask

  // Payload source for dut0: offers queued bytes, honouring per-byte idle gaps.
  initial begin : feeder
    logic hs;
    wdata_valid0 = 1'b0;
    wdata0 = 8'h00;
    forever begin
      @(negedge clk);
      hs = rst_n && wdata_valid0 && wdata_ready_s[0];
      @(posedge clk);
      #1;
      if (hs) begin
        wd_hs_cnt++;
        if (pay_q.size() > 0) begin
          pay_q.delete(0);
          gap_q.delete(0);
        end
      end
      if (pay_q.size() > 0 && gap_q.size() > 0) begin
        if (gap_q[0] > 0) begin
          wdata_valid0 = 1'b0;
          gap_q[0] = gap_q[0] - 1;
        end else begin
          wdata_valid0 = 1'b1;
          wdata0 = pay_q[0];
        end
      end else begin
        wdata_valid0 = 1'b0;
      end
    end
  end

  // Compare process: every handshake, stall and idle cycle against the model.
  initial begin : compare
    logic [7:0] prev_d [2];
    logic       prev_stall [2];
    logic [7:0] e;
    bit         have;
    prev_stall[0] = 1'b0;
    prev_stall[1] = 1'b0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (!rst_n) begin
          prev_stall[k] = 1'b0;
        end else begin
          if (prev_stall[k]) begin
            chk("stall_valid", 32'(tx_valid_s[k]), 32'd1);
            chk("stall_data", 32'(tx_data_s[k]), 32'(prev_d[k]));
          end
          if (!busy_s[k]) begin
            chk("idle_tx_valid", 32'(tx_valid_s[k]), 32'd0);
            chk("idle_wdata_ready", 32'(wdata_ready_s[k]), 32'd0);
          end
          if (k == 0 && busy_s[0] && !tx_valid_s[0]) bubble_cnt++;
          if (tx_valid_s[k] && tx_ready[k]) begin
            hs_cnt[k]++;
            if (hs_cnt[k] == 1) first_hs[k] = cyc + 1;
            last_hs[k] = cyc + 1;
            have = 1'b1;
            e = 8'h00;
            if (k == 0 && exp_q0.size() > 0)      e = exp_q0.pop_front();
            else if (k == 1 && exp_q1.size() > 0) e = exp_q1.pop_front();
            else                                  have = 1'b0;
            if (have) begin
              chk("tx_byte", 32'(tx_data_s[k]), 32'(e));
            end else begin
              n_cmp++; n_bad++;
              $display("FAIL tx_unexpected dut%0d: got byte %h expected no byte", k, tx_data_s[k]);
            end
          end
          prev_stall[k] = tx_valid_s[k] && !tx_ready[k];
          prev_d[k] = tx_data_s[k];
        end
      end
    end
  end

  task automatic write_frame_setup(input int gap2);
    tmp_pay.delete(); tmp_gap.delete();
    add_pay(8'hAA, 0);
    add_pay(8'h55, gap2);
    expect_frame(0, 1'b1, 1'b1, 2'd0, 8'd1, 32'h4321_1234, 4, 1'b1);
  endtask

  initial begin : main
    rst_n = 1'b1;
    tx_ready[0] = 1'b1; tx_ready[1] = 1'b1;
    mreq_valid[0] = 1'b0; mreq_valid[1] = 1'b0;
    mreq0 = 44'h0; mreq1 = 28'h0;
    hs_cnt[0] = 0; hs_cnt[1] = 0;
    first_hs[0] = 0; first_hs[1] = 0;
    last_hs[0] = 0; last_hs[1] = 0;

    // Reset values, without and then with a clock edge.
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_tx_valid", 32'(tx_valid_s[k]), 32'd0);
      chk("rst_tx_data", 32'(tx_data_s[k]), 32'd0);
      chk("rst_mreq_ready", 32'(mreq_ready_s[k]), 32'd0);
      chk("rst_wdata_ready", 32'(wdata_ready_s[k]), 32'd0);
      chk("rst_busy", 32'(busy_s[k]), 32'd0);
    end
    #20 rst_n = 1'b1;
    #1 chk("mreq_ready_before_edge", 32'(mreq_ready_s[0]), 32'd0);
    @(posedge clk);
    #1;
    chk("mreq_ready_first_edge0", 32'(mreq_ready_s[0]), 32'd1);
    chk("mreq_ready_first_edge1", 32'(mreq_ready_s[1]), 32'd1);

    // Read frame, back-to-back bytes with fixed latency.
    tmp_pay.delete(); tmp_gap.delete();
    expect_frame(0, 1'b0, 1'b1, 2'd1, 8'd5, 32'h1234_5678, 4, 1'b1);
    lit = {8'h53, 8'h05, 8'h12, 8'h34, 8'h56, 8'h78, 8'h5E};
    pin("pin_read");
    hs_cnt[0] = 0;
    send_req(0, {1'b0, 1'b1, 2'd1, 8'd5, 32'h1234_5678});
    wait_done(0, 1'b0, 40);
    chk("read_first_latency", 32'(first_hs[0]), 32'(accept_cyc + 1));
    chk("read_last_cycle", 32'(last_hs[0]), 32'(accept_cyc + 7));
    chk("read_byte_count", 32'(hs_cnt[0]), 32'd7);

    // Write frame with two payload bytes offered before the request.
    write_frame_setup(0);
    lit = {8'hC3, 8'h01, 8'h43, 8'h21, 8'h12, 8'h34, 8'hAA, 8'h55, 8'h79};
    pin("pin_write");
    wd_hs_cnt = 0;
    send_req(0, {1'b1, 1'b1, 2'd0, 8'd1, 32'h4321_1234});
    wait_done(0, 1'b0, 40);
    chk("write_wdata_hs", 32'(wd_hs_cnt), 32'd2);

    // Same write with the sink stalled for 10 cycles on the first byte.
    write_frame_setup(0);
    wd_hs_cnt = 0;
    send_req(0, {1'b1, 1'b1, 2'd0, 8'd1, 32'h4321_1234});
    tx_ready[0] = 1'b0;
    repeat (10) @(posedge clk);
    #1 tx_ready[0] = 1'b1;
    wait_done(0, 1'b0, 40);
    chk("stall_wdata_hs", 32'(wd_hs_cnt), 32'd2);

    // Same write with a 3-cycle payload gap before the second byte.
    write_frame_setup(3);
    wd_hs_cnt = 0;
    send_req(0, {1'b1, 1'b1, 2'd0, 8'd1, 32'h4321_1234});
    bubble_cnt = 0;
    wait_done(0, 1'b0, 40);
    chk("bubble_cycles_ge3", 32'(bubble_cnt >= 3), 32'd1);
    chk("bubble_wdata_hs", 32'(wd_hs_cnt), 32'd2);

    // Two address bytes, no checksum.
    tmp_pay.delete(); tmp_gap.delete();
    expect_frame(1, 1'b0, 1'b0, 2'd0, 8'd0, 32'h0000_BEEF, 2, 1'b0);
    lit = {8'h01, 8'h00, 8'hBE, 8'hEF};
    pin("pin_short");
    send_req(1, {16'h0, 1'b0, 1'b0, 2'd0, 8'd0, 16'hBEEF});
    wait_done(1, 1'b0, 20);

    // Largest payload: 256 beats of 4 bytes, random sink stalls.
    tmp_pay.delete(); tmp_gap.delete();
    for (int i = 0; i < 1024; i++) add_pay(8'(i) ^ 8'h3C, 0);
    expect_frame(0, 1'b1, 1'b0, 2'd2, 8'd255, 32'hA5A5_0001, 4, 1'b1);
    chk("pin_max_frame_len", 32'(frame_q.size()), 32'd1031);
    wd_hs_cnt = 0;
    send_req(0, {1'b1, 1'b0, 2'd2, 8'd255, 32'hA5A5_0001});
    wait_done(0, 1'b1, 4000);
    chk("max_wdata_hs", 32'(wd_hs_cnt), 32'd1024);

    // wsize 3 behaves as 4-byte beats; gappy source and stalling sink.
    tmp_pay.delete(); tmp_gap.delete();
    for (int i = 0; i < 12; i++) add_pay(8'(8'h90 + 8'(i)), int'($urandom_range(0, 2)));
    expect_frame(0, 1'b1, 1'b1, 2'd3, 8'd2, 32'h0F0E_0D0C, 4, 1'b1);
    wd_hs_cnt = 0;
    send_req(0, {1'b1, 1'b1, 2'd3, 8'd2, 32'h0F0E_0D0C});
    wait_done(0, 1'b1, 200);
    chk("wsize3_wdata_hs", 32'(wd_hs_cnt), 32'd12);

    // Reset in the middle of a slow payload, then a clean frame.
    tmp_pay.delete(); tmp_gap.delete();
    for (int i = 0; i < 8; i++) add_pay(8'(8'h10 + 8'(i)), 2);
    expect_frame(0, 1'b1, 1'b0, 2'd0, 8'd7, 32'h0102_0304, 4, 1'b1);
    send_req(0, {1'b1, 1'b0, 2'd0, 8'd7, 32'h0102_0304});
    repeat (12) @(posedge clk);
    #2 chk("busy_before_reset", 32'(busy_s[0]), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("midrst_tx_valid", 32'(tx_valid_s[k]), 32'd0);
      chk("midrst_tx_data", 32'(tx_data_s[k]), 32'd0);
      chk("midrst_mreq_ready", 32'(mreq_ready_s[k]), 32'd0);
      chk("midrst_wdata_ready", 32'(wdata_ready_s[k]), 32'd0);
      chk("midrst_busy", 32'(busy_s[k]), 32'd0);
    end
    exp_q0.delete();
    pay_q.delete();
    gap_q.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1 chk("mreq_ready_after_midrst", 32'(mreq_ready_s[0]), 32'd1);
    write_frame_setup(1);
    wd_hs_cnt = 0;
    send_req(0, {1'b1, 1'b1, 2'd0, 8'd1, 32'h4321_1234});
    wait_done(0, 1'b0, 40);
    chk("recover_wdata_hs", 32'(wd_hs_cnt), 32'd2);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
